// File: rtl/pack_arb_sched_if.sv
// Bundle of the two byte-source streams and the packed-word write port of pack_arb_sched.
// The master view belongs to the packer; the slave view belongs to the sources and memory side.
interface pack_arb_sched_if #(
  parameter int ADDR_W = 10
);
  logic              s0_valid;
  logic [7:0]        s0_data;
  logic              s0_ready;
  logic              s1_valid;
  logic [7:0]        s1_data;
  logic              s1_ready;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_ack;
  logic [1:0]        frame_done;
  logic              busy;

  modport master (
    input  s0_valid, s0_data, s1_valid, s1_data, wr_ack,
    output s0_ready, s1_ready, wr_req, wr_addr, wr_data, frame_done, busy
  );

  modport slave (
    output s0_valid, s0_data, s1_valid, s1_data, wr_ack,
    input  s0_ready, s1_ready, wr_req, wr_addr, wr_data, frame_done, busy
  );
endinterface

// File: rtl/pack_arb_sched.sv
// Packs four bytes from one of two round-robin arbitrated sources into a 32-bit word
// and writes it to that source's circular region, pulsing frame_done when the region wraps.
module pack_arb_sched #(
  parameter int ADDR_W = 10,
  parameter int BASE0  = 0,
  parameter int BASE1  = 512,
  parameter int DEPTH  = 512
) (
  input  logic               clk,
  input  logic               rst,
  pack_arb_sched_if.master   bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, GATHER = 2'd1, WRITE = 2'd2} state_t;

  localparam logic [ADDR_W-1:0] L_BASE0 = ADDR_W'(BASE0);
  localparam logic [ADDR_W-1:0] L_BASE1 = ADDR_W'(BASE1);
  localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_grant;
  logic              r_last_grant;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_word;
  logic [ADDR_W-1:0] r_ptr [2];
  logic              r_wr_req;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic [1:0]        r_frame_done;

  logic              w_any_valid;
  logic              w_grant_sel;
  logic              w_accept;
  logic              w_ack;
  logic              w_wrap;
  logic [7:0]        w_data;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_ptr_nxt;

  assign w_any_valid = bus.s0_valid | bus.s1_valid;
  // On a tie the source that did not win last time gets the word; a lone requester always wins.
  assign w_grant_sel = (bus.s0_valid && bus.s1_valid) ? ~r_last_grant : bus.s1_valid;
  assign w_data      = r_grant ? bus.s1_data : bus.s0_data;
  assign w_accept    = (r_state == GATHER) && (r_grant ? bus.s1_valid : bus.s0_valid);
  assign w_ack       = (r_state == WRITE) && bus.wr_ack;
  assign w_base      = r_grant ? L_BASE1 : L_BASE0;
  assign w_wrap      = (r_ptr[r_grant] == L_LAST);
  assign w_ptr_nxt   = w_wrap ? '0 : r_ptr[r_grant] + ADDR_W'(1);

  assign bus.s0_ready   = (r_state == GATHER) && !r_grant;
  assign bus.s1_ready   = (r_state == GATHER) && r_grant;
  assign bus.wr_req     = r_wr_req;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.frame_done = r_frame_done;
  assign bus.busy       = (r_state != IDLE);

  // NOTE: the default ahead of the case keeps every path assigned, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any_valid) w_next_state = GATHER;
      GATHER:  if (w_accept && r_byte_cnt == 2'd3) w_next_state = WRITE;
      WRITE:   if (bus.wr_ack) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_byte_cnt   <= 2'd0;
      r_word       <= '0;
      // NOTE: the two pointers are plain flops, not a RAM, so they take the reset like any register.
      r_ptr[0]     <= '0;
      r_ptr[1]     <= '0;
      r_wr_req     <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= '0;
    end else begin
      r_state      <= w_next_state;
      r_frame_done <= '0;

      if (r_state == IDLE && w_any_valid) begin
        r_grant    <= w_grant_sel;
        r_byte_cnt <= 2'd0;
      end

      if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0: r_word[7:0]   <= w_data;
          2'd1: r_word[15:8]  <= w_data;
          2'd2: r_word[23:16] <= w_data;
          default: begin
            r_wr_req  <= 1'b1;
            r_wr_data <= {w_data, r_word};
            r_wr_addr <= w_base + r_ptr[r_grant];
          end
        endcase
      end

      // Address and data stay parked after the ack; only wr_req signals a live write.
      if (w_ack) begin
        r_wr_req                <= 1'b0;
        r_last_grant            <= r_grant;
        r_ptr[r_grant]          <= w_ptr_nxt;
        r_frame_done[r_grant]   <= w_wrap;
      end
    end
  end
endmodule

// File: tb/tb_pack_arb_sched.sv
// Bench for pack_arb_sched: directed protocol scenarios, then random traffic scored against a
// word-level model (per-source byte streams, per-region pointers, expected write queue).
module tb_pack_arb_sched;
  localparam int AW    = 10;
  localparam int BASE0 = 0;
  localparam int BASE1 = 512;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [1:0]    fd;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pack_arb_sched_if #(.ADDR_W(AW)) bus ();

  pack_arb_sched #(
    .ADDR_W(AW), .BASE0(BASE0), .BASE1(BASE1), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // random-phase model state
  int          cnt   [2];
  int          ptr_m [2];
  logic [31:0] acc   [2];
  logic [7:0]  nxt   [2];
  bit          v     [2];
  wr_t         exp_q [$];
  bit          req_due;
  bit          drop_due;
  logic [1:0]  fd_exp;
  int          n_wr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic vld, input logic [7:0] d);
    if (s == 0) begin
      bus.s0_valid = vld;
      bus.s0_data  = d;
    end else begin
      bus.s1_valid = vld;
      bus.s1_data  = d;
    end
  endtask

  function automatic logic rdy(input int s);
    return (s == 0) ? bus.s0_ready : bus.s1_ready;
  endfunction

  task automatic idle_inputs();
    set_src(0, 1'b0, 8'h00);
    set_src(1, 1'b0, 8'h00);
    bus.wr_ack = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rdy0"}, bus.s0_ready, 0);
    check({tag, "_rdy1"}, bus.s1_ready, 0);
    check({tag, "_req"},  bus.wr_req, 0);
    check({tag, "_addr"}, bus.wr_addr, 0);
    check({tag, "_data"}, bus.wr_data, 0);
    check({tag, "_fd"},   bus.frame_done, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Offers word w from src starting in IDLE, optionally with the other source also requesting and
  // a valid gap after two bytes; checks latency, write contents, hold while unacked, and release.
  task automatic send_word(input int src, input logic [31:0] w, input int ack_dly,
                           input logic [AW-1:0] exp_addr, input bit other_v,
                           input int gap_len, input int exp_cyc);
    int  k = 0;
    int  n = 0;
    bit  gapped = 1'b0;
    set_src(src, 1'b1, w[7:0]);
    if (other_v) set_src(1 - src, 1'b1, 8'hA5);
    while (k < 4 && n < 60) begin
      if (k == 2 && !gapped && gap_len > 0) begin
        set_src(src, 1'b0, w[23:16]);
        for (int g = 0; g < gap_len; g++) begin
          check("gap_own_rdy", rdy(src), 1);
          check("gap_other_rdy", rdy(1 - src), 0);
          cyc();
          n++;
        end
        gapped = 1'b1;
        set_src(src, 1'b1, w[23:16]);
      end
      check("other_rdy", rdy(1 - src), 0);
      if (rdy(src)) k++;
      bus.wr_ack = n[0];
      cyc();
      n++;
      if (k < 4) set_src(src, 1'b1, w[8*k +: 8]);
    end
    bus.wr_ack = 1'b0;
    check("word_latency", n, exp_cyc);
    for (int d = 0; d <= ack_dly; d++) begin
      check("wr_req", bus.wr_req, 1);
      check("wr_addr", bus.wr_addr, exp_addr);
      check("wr_data", bus.wr_data, w);
      check("wr_rdy0", bus.s0_ready, 0);
      check("wr_rdy1", bus.s1_ready, 0);
      check("wr_busy", bus.busy, 1);
      if (d == ack_dly) bus.wr_ack = 1'b1;
      cyc();
      bus.wr_ack = 1'b0;
    end
    check("req_drop", bus.wr_req, 0);
    check("idle_busy", bus.busy, 0);
  endtask

  // Accepts nb bytes of w from src, then withdraws the source.
  task automatic gather_n(input int src, input logic [31:0] w, input int nb);
    int k = 0;
    int n = 0;
    set_src(src, 1'b1, w[7:0]);
    while (k < nb && n < 20) begin
      if (rdy(src)) k++;
      cyc();
      n++;
      if (k < 4) set_src(src, 1'b1, w[8*k +: 8]);
    end
    set_src(src, 1'b0, 8'h00);
    check("gather_n", k, nb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // reset values while rst is held
    idle_inputs();
    #3;
    check_zero("reset");
    cyc();
    cyc();
    rst = 1'b0;

    // single source, ack on the first WRITE cycle, consecutive addresses
    send_word(0, 32'h44332211, 0, 10'd0, 1'b0, 0, 5);
    send_word(0, 32'h88776655, 0, 10'd1, 1'b0, 0, 5);

    // both sources requesting: grants alternate starting with source 0
    do_reset();
    send_word(0, 32'hA0A1A2A3, 0, 10'd0,   1'b1, 0, 5);
    send_word(1, 32'hB0B1B2B3, 0, 10'd512, 1'b1, 0, 5);
    send_word(0, 32'hC0C1C2C3, 0, 10'd1,   1'b1, 0, 5);
    send_word(1, 32'hD0D1D2D3, 0, 10'd513, 1'b1, 0, 5);

    // delayed ack: write held for six cycles
    do_reset();
    send_word(1, 32'hDEADBEEF, 5, 10'd512, 1'b0, 0, 5);

    // region 1 wraps after DEPTH words
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_word(1, $urandom, 0, AW'(512 + i), 1'b0, 0, 5);
      check("fd_pulse", bus.frame_done, (i == 3) ? 2'b10 : 2'b00);
      set_src(1, 1'b0, 8'h00);
      cyc();
      check("fd_after", bus.frame_done, 2'b00);
    end
    send_word(1, 32'h0BADF00D, 0, 10'd512, 1'b0, 0, 5);

    // source 0 stalls mid-word while source 1 waits; no preemption, then source 1 next
    do_reset();
    send_word(0, 32'h12345678, 0, 10'd0,   1'b1, 3, 8);
    send_word(1, 32'h9ABCDEF0, 0, 10'd512, 1'b1, 0, 5);

    // reset mid-GATHER discards the partial word
    do_reset();
    gather_n(0, 32'h11111111, 3);
    #2 rst = 1'b1;
    #1 check_zero("rst_gather");
    cyc();
    cyc();
    rst = 1'b0;
    send_word(0, 32'hCAFEF00D, 0, 10'd0, 1'b0, 0, 5);

    // reset mid-WRITE drops the pending write for good
    set_src(0, 1'b0, 8'h00);
    cyc();
    gather_n(0, 32'h55AA55AA, 4);
    check("pre_rst_req", bus.wr_req, 1);
    check("pre_rst_addr", bus.wr_addr, 10'd1);
    #2 rst = 1'b1;
    #1 check_zero("rst_write");
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("post_rst_req", bus.wr_req, 0);
    end

    // random traffic against the word-level model
    do_reset();
    for (int x = 0; x < 2; x++) begin
      cnt[x]   = 0;
      ptr_m[x] = 0;
      acc[x]   = '0;
      nxt[x]   = 8'($urandom);
    end
    req_due  = 1'b0;
    drop_due = 1'b0;
    fd_exp   = 2'b00;
    n_wr     = 0;
    for (int c = 0; c < 4000; c++) begin
      check("rnd_fd", bus.frame_done, fd_exp);
      if (req_due)  check("rnd_req_rise", bus.wr_req, 1);
      if (drop_due) check("rnd_req_drop", bus.wr_req, 0);
      if (bus.wr_req) begin
        if (exp_q.size() == 0) begin
          check("rnd_wr_spurious", bus.wr_req, 0);
        end else begin
          check("rnd_wr_addr", bus.wr_addr, exp_q[0].addr);
          check("rnd_wr_data", bus.wr_data, exp_q[0].data);
        end
      end
      check("rnd_rdy_excl", bus.s0_ready & bus.s1_ready, 0);
      for (int x = 0; x < 2; x++)
        if (cnt[x] != 0) check("rnd_grant_hold", rdy(1 - x), 0);
      check("rnd_busy", bus.busy, bus.s0_ready | bus.s1_ready | bus.wr_req);

      for (int x = 0; x < 2; x++) begin
        v[x] = ($urandom_range(0, 9) < 7);
        set_src(x, v[x], nxt[x]);
      end
      bus.wr_ack = ($urandom_range(0, 2) == 0);

      req_due  = 1'b0;
      drop_due = 1'b0;
      fd_exp   = 2'b00;
      for (int x = 0; x < 2; x++) begin
        if (v[x] && rdy(x)) begin
          acc[x][8*cnt[x] +: 8] = nxt[x];
          cnt[x]++;
          nxt[x] = 8'($urandom);
          if (cnt[x] == 4) begin
            wr_t e;
            e.addr   = AW'(((x == 0) ? BASE0 : BASE1) + ptr_m[x]);
            e.data   = acc[x];
            e.fd     = (ptr_m[x] == DEPTH - 1) ? 2'(1 << x) : 2'b00;
            ptr_m[x] = (ptr_m[x] + 1) % DEPTH;
            exp_q.push_back(e);
            cnt[x]   = 0;
            req_due  = 1'b1;
          end
        end
      end
      if (bus.wr_req && bus.wr_ack && exp_q.size() > 0) begin
        drop_due = 1'b1;
        fd_exp   = exp_q[0].fd;
        void'(exp_q.pop_front());
        n_wr++;
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
